// File: rtl/msg_assembler_if.sv
// Word-in / message-out bus for msg_assembler.
//   data_in, data_in_valid   : one word per valid cycle, no backpressure
//   data_out, data_out_valid : last completed message and its one-cycle pulse
// master drives words and observes messages; slave is the assembler side.
interface msg_assembler_if #(
  parameter int unsigned WORD_SIZE        = 8,
  parameter int unsigned WORDS_PER_PACKET = 4
);
  logic [WORD_SIZE-1:0]                  data_in;
  logic                                  data_in_valid;
  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out;
  logic                                  data_out_valid;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid
  );
endinterface

// File: rtl/msg_assembler.sv
// Message assembler: packs every WORDS_PER_PACKET accepted words into one
// message, first word in the most-significant position.
// Ports:
//   clk     : rising-edge clock
//   n_reset : asynchronous active-low reset
//   bus     : msg_assembler_if.slave (data_in/data_in_valid in,
//             data_out/data_out_valid out, both outputs registered)
module msg_assembler #(
  parameter int unsigned WORD_SIZE        = 8,
  parameter int unsigned WORDS_PER_PACKET = 4
) (
  input  logic            clk,
  input  logic            n_reset,
  msg_assembler_if.slave  bus
);

  localparam int unsigned MSG_W = WORD_SIZE * WORDS_PER_PACKET;
  localparam int unsigned CNT_W = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [MSG_W-1:0] out_q;
  logic             vld_q;
  logic [MSG_W-1:0] msg_next_c;
  logic             last_c;

  // Current word closes the message being assembled.
  assign last_c = bus.data_in_valid && (cnt_q == CNT_W'(WORDS_PER_PACKET - 1));

  // Assembly history: only the older WORDS_PER_PACKET-1 words need storing,
  // the oldest word of the full-width shift result would be discarded anyway.
  if (WORDS_PER_PACKET == 1) begin : g_single
    assign msg_next_c = bus.data_in;
  end else begin : g_multi
    localparam int unsigned HOLD_W = (WORDS_PER_PACKET - 1) * WORD_SIZE;
    logic [HOLD_W-1:0] hold_q;

    assign msg_next_c = {hold_q, bus.data_in};

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        hold_q <= '0;
      end else if (bus.data_in_valid) begin
        hold_q <= msg_next_c[HOLD_W-1:0];
      end
    end
  end

  // Word counter, output holding register and completion pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.data_in_valid) begin
        if (last_c) begin
          cnt_q <= '0;
          out_q <= msg_next_c;
          vld_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_out       = out_q;
  assign bus.data_out_valid = vld_q;

endmodule

// File: tb/tb_msg_assembler.sv
// Scoreboard bench for msg_assembler: three instances (8x4, 8x1, 4x3).
// Stimulus pushes hand-computed messages with their expected pulse cycle;
// per-instance monitors pop and compare on every data_out_valid.
module tb_msg_assembler;

  logic clk;
  logic n_reset;
  int   cyc;
  int   checks;
  int   errors;

  msg_assembler_if #(.WORD_SIZE(8), .WORDS_PER_PACKET(4)) if_a ();
  msg_assembler_if #(.WORD_SIZE(8), .WORDS_PER_PACKET(1)) if_b ();
  msg_assembler_if #(.WORD_SIZE(4), .WORDS_PER_PACKET(3)) if_c ();

  msg_assembler #(.WORD_SIZE(8), .WORDS_PER_PACKET(4)) dut_a (.clk(clk), .n_reset(n_reset), .bus(if_a));
  msg_assembler #(.WORD_SIZE(8), .WORDS_PER_PACKET(1)) dut_b (.clk(clk), .n_reset(n_reset), .bus(if_b));
  msg_assembler #(.WORD_SIZE(4), .WORDS_PER_PACKET(3)) dut_c (.clk(clk), .n_reset(n_reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected messages (zero-extended) and the cycle their pulse must appear in.
  logic [31:0] dat_a[$], dat_b[$], dat_c[$];
  int          tim_a[$], tim_b[$], tim_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [31:0] act,
                         inout logic [31:0] dq[$], inout int tq[$]);
    logic [31:0] d;
    int          t;
    checks++;
    if (dq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse data_out=%h at cycle %0d, expected no pulse", name, act, cyc);
    end else begin
      d = dq.pop_front();
      t = tq.pop_front();
      if (act !== d || cyc != t) begin
        errors++;
        $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", name, act, cyc, d, t);
      end
    end
  endtask

  // Monitors: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) if (if_a.data_out_valid === 1'b1) pop_cmp("msg_a", 32'(if_a.data_out), dat_a, tim_a);
  always @(negedge clk) if (if_b.data_out_valid === 1'b1) pop_cmp("msg_b", 32'(if_b.data_out), dat_b, tim_b);
  always @(negedge clk) if (if_c.data_out_valid === 1'b1) pop_cmp("msg_c", 32'(if_c.data_out), dat_c, tim_c);

  // Each word task drives for one cycle; the pulse is due one edge later.
  task automatic word_a(input logic [7:0] w, input bit last, input logic [31:0] exp);
    if_a.data_in = w;
    if_a.data_in_valid = 1'b1;
    if (last) begin
      dat_a.push_back(exp);
      tim_a.push_back(cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic word_b(input logic [7:0] w, input logic [31:0] exp);
    if_b.data_in = w;
    if_b.data_in_valid = 1'b1;
    dat_b.push_back(exp);
    tim_b.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic word_c(input logic [3:0] w, input bit last, input logic [31:0] exp);
    if_c.data_in = w;
    if_c.data_in_valid = 1'b1;
    if (last) begin
      dat_c.push_back(exp);
      tim_c.push_back(cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_a.data_in_valid = 1'b0;
    if_b.data_in_valid = 1'b0;
    if_c.data_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_reset = 1'b0;
    if_a.data_in = '0; if_a.data_in_valid = 1'b0;
    if_b.data_in = '0; if_b.data_in_valid = 1'b0;
    if_c.data_in = '0; if_c.data_in_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_data_a", 32'(if_a.data_out), 32'h0);
    chk("reset_valid_a", 32'(if_a.data_out_valid), 32'h0);
    chk("reset_data_c", 32'(if_c.data_out), 32'h0);
    n_reset = 1'b1;
    idle(3);
    chk("post_reset_data_a", 32'(if_a.data_out), 32'h0);

    // Spaced single-cycle strobes
    word_a(8'h00, 1'b0, 32'h0); idle(2);
    word_a(8'h01, 1'b0, 32'h0); idle(1);
    word_a(8'h02, 1'b0, 32'h0); idle(3);
    chk("partial_data_a", 32'(if_a.data_out), 32'h0);
    word_a(8'h03, 1'b1, 32'h00010203); idle(3);
    chk("hold_after_msg1", 32'(if_a.data_out), 32'h00010203);

    // Second message: previous message held during assembly
    word_a(8'hFF, 1'b0, 32'h0); idle(1);
    chk("hold_w0", 32'(if_a.data_out), 32'h00010203);
    word_a(8'hFE, 1'b0, 32'h0); idle(1);
    chk("hold_w1", 32'(if_a.data_out), 32'h00010203);
    word_a(8'hFD, 1'b0, 32'h0);
    chk("hold_w2", 32'(if_a.data_out), 32'h00010203);
    word_a(8'hFC, 1'b1, 32'hFFFEFDFC); idle(2);
    chk("hold_after_msg2", 32'(if_a.data_out), 32'hFFFEFDFC);

    // Back-to-back full-rate words
    word_a(8'h10, 1'b0, 32'h0);
    word_a(8'h11, 1'b0, 32'h0);
    word_a(8'h12, 1'b0, 32'h0);
    word_a(8'h13, 1'b1, 32'h10111213);
    word_a(8'h14, 1'b0, 32'h0);
    word_a(8'h15, 1'b0, 32'h0);
    word_a(8'h16, 1'b0, 32'h0);
    word_a(8'h17, 1'b1, 32'h14151617);
    idle(3);

    // Parameter sweep: one word per message, and 4-bit x 3 words
    word_b(8'h5A, 32'h0000005A);
    idle(1);
    word_b(8'hC3, 32'h000000C3);
    word_b(8'h3C, 32'h0000003C);
    idle(2);
    chk("hold_b", 32'(if_b.data_out), 32'h3C);
    word_c(4'h1, 1'b0, 32'h0); idle(1);
    word_c(4'h2, 1'b0, 32'h0);
    word_c(4'h3, 1'b1, 32'h00000123);
    idle(3);

    // Reset mid-packet: aborted words must not produce a pulse
    word_a(8'hAA, 1'b0, 32'h0);
    word_a(8'hBB, 1'b0, 32'h0);
    idle(0);
    #2 n_reset = 1'b0;
    #1;
    chk("async_reset_data_a", 32'(if_a.data_out), 32'h0);
    chk("async_reset_valid_a", 32'(if_a.data_out_valid), 32'h0);
    chk("async_reset_data_b", 32'(if_b.data_out), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    idle(1);
    chk("after_reset_data_a", 32'(if_a.data_out), 32'h0);
    word_a(8'h01, 1'b0, 32'h0);
    word_a(8'h02, 1'b0, 32'h0);
    idle(1);
    word_a(8'h03, 1'b0, 32'h0);
    chk("after_reset_partial_a", 32'(if_a.data_out), 32'h0);
    word_a(8'h04, 1'b1, 32'h01020304);
    idle(4);

    // Every expected pulse must have been seen
    chk("pending_a", 32'(dat_a.size()), 32'h0);
    chk("pending_b", 32'(dat_b.size()), 32'h0);
    chk("pending_c", 32'(dat_c.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
